hazard_scoreboard_unit: RTL and testbench

//  Next-generation ID-stage hazard controller for the RV32 core. A per-register scoreboard stalls on
//  RAW/WAW against in-flight long-latency ops (loads, multi-cycle ALU) of any latency. It also

---
 rtl/hazard_scoreboard_if.sv | 41 ++++
 rtl/hazard_scoreboard_unit.sv | 115 +++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard controller bus: pipeline/memory status in, stall/flush/perf controls out.
// master = core side driving the status, slave = the hazard unit.
interface hazard_scoreboard_if #(
  parameter int MAX_PENDING = 4,
  parameter int CNT_W       = 32
);
  localparam int PC_W = $clog2(MAX_PENDING + 1);

  logic             id_valid;
  logic [4:0]       rs1_id;
  logic [4:0]       rs2_id;
  logic [4:0]       rd_id;
  logic             id_regwrite;
  logic             id_longlat;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic             branch_taken;
  logic             imem_ready;
  logic             dmem_valid;
  logic             dmem_ready;
  logic             stall;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             mem_timeout;
  logic [PC_W-1:0]  pending_cnt;
  logic [CNT_W-1:0] stall_cycles;
  logic [1:0]       fsm_state;

  // Handshake: an ID instruction is accepted in a cycle where id_valid=1 and
  // stall=0 and branch_taken=0; otherwise the core must hold it unchanged.
  modport master (
    output id_valid, rs1_id, rs2_id, rd_id, id_regwrite, id_longlat,
    output wb_valid, wb_rd, branch_taken, imem_ready, dmem_valid, dmem_ready,
    input  stall, flush_if_id, flush_id_ex, mem_timeout, pending_cnt, stall_cycles, fsm_state
  );
  modport slave (
    input  id_valid, rs1_id, rs2_id, rd_id, id_regwrite, id_longlat,
    input  wb_valid, wb_rd, branch_taken, imem_ready, dmem_valid, dmem_ready,
    output stall, flush_if_id, flush_id_ex, mem_timeout, pending_cnt, stall_cycles, fsm_state
  );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// ID-stage hazard controller: per-register scoreboard for long-latency ops, memory-wait
// freeze with watchdog, branch flushes and stall/pending performance counters.
module hazard_scoreboard_unit #(
  parameter int NUM_REGS    = 32,
  parameter int MAX_PENDING = 4,
  parameter int TIMEOUT     = 256,
  parameter int CNT_W       = 32,
  parameter int WB_BYPASS   = 1
) (
  input logic               clk,
  input logic               rst,
  hazard_scoreboard_if.slave bus
);
  localparam int PC_W   = $clog2(MAX_PENDING + 1);
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [NUM_REGS-1:0] sb_q, sb_next, sb_eff, wb_onehot;
  logic [PC_W-1:0]     pending_q, pending_d;
  logic [CNT_W-1:0]    sc_q;

  logic mem_stall, raw, waw, full, sb_hz, stall_int, issue;

  always_comb begin
    mem_stall = !bus.imem_ready | (bus.dmem_valid & !bus.dmem_ready);
    wb_onehot = bus.wb_valid ? (NUM_REGS'(1) << bus.wb_rd) : '0;
    sb_eff    = (WB_BYPASS != 0) ? (sb_q & ~wb_onehot) : sb_q;

    raw   = bus.id_valid & (((bus.rs1_id != 5'd0) & sb_eff[bus.rs1_id]) |
                            ((bus.rs2_id != 5'd0) & sb_eff[bus.rs2_id]));
    waw   = bus.id_valid & bus.id_regwrite & (bus.rd_id != 5'd0) & sb_eff[bus.rd_id];
    // Capacity uses the registered count: a writeback this cycle frees a slot only next cycle.
    full  = bus.id_valid & bus.id_longlat & bus.id_regwrite & (bus.rd_id != 5'd0) &
            (pending_q == PC_W'(MAX_PENDING));
    sb_hz = raw | waw | full;

    stall_int = mem_stall | sb_hz | (state_q == ST_FAULT);
    issue     = bus.id_valid & !stall_int & !bus.branch_taken;

    bus.stall       = !rst & stall_int;
    bus.flush_if_id = !rst & bus.branch_taken & !mem_stall;
    bus.flush_id_ex = !rst & (bus.branch_taken | sb_hz) & !mem_stall;
    bus.mem_timeout = (state_q == ST_FAULT);
    bus.pending_cnt = pending_q;
    bus.stall_cycles = sc_q;
    bus.fsm_state   = state_q;
  end

  // Clear first, then set, so an issue to a register retiring in the same cycle keeps it pending.
  always_comb begin
    sb_next = sb_q;
    if (bus.wb_valid && bus.wb_rd != 5'd0)
      sb_next[bus.wb_rd] = 1'b0;
    if (issue && bus.id_longlat && bus.id_regwrite && bus.rd_id != 5'd0)
      sb_next[bus.rd_id] = 1'b1;
    sb_next[0] = 1'b0;

    pending_d = '0;
    for (int i = 0; i < NUM_REGS; i++)
      pending_d = pending_d + PC_W'(sb_next[i]);
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall) begin
          state_d = ST_MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_stall) begin
          state_d = ST_RUN;
          wait_d  = '0;
        end else if (TIMEOUT != 0 && wait_q >= WAIT_W'(TO_LIM)) begin
          state_d = ST_FAULT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default: begin
        state_d = ST_RUN;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      wait_q    <= '0;
      sb_q      <= '0;
      pending_q <= '0;
      sc_q      <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      sb_q      <= sb_next;
      pending_q <= pending_d;
      if (stall_int && sc_q != '1)
        sc_q <= sc_q + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: each cycle pushes the expected output vector,
// then pops and checks it mid-cycle; stall_cycles is checked against a bench-side count.
module tb_hazard_scoreboard_unit;
  localparam int MAX_PENDING = 4;
  localparam int CNT_W       = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.MAX_PENDING(MAX_PENDING), .CNT_W(CNT_W)) bus ();

  hazard_scoreboard_unit #(
    .NUM_REGS(32), .MAX_PENDING(MAX_PENDING), .TIMEOUT(8), .CNT_W(CNT_W), .WB_BYPASS(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Expected vector: {stall, flush_if_id, flush_id_ex, mem_timeout, pending_cnt[2:0]}
  logic [6:0]       exp_q[$];
  string            tag_q[$];
  logic [CNT_W-1:0] exp_sc = '0;
  int checks = 0;
  int errors = 0;

  function automatic logic [6:0] pk(bit s, bit fi, bit fe, bit to, int pc);
    return {s, fi, fe, to, 3'(pc)};
  endfunction

  task automatic idle();
    bus.id_valid = 1'b0; bus.rs1_id = '0; bus.rs2_id = '0; bus.rd_id = '0;
    bus.id_regwrite = 1'b0; bus.id_longlat = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.branch_taken = 1'b0;
    bus.imem_ready = 1'b1; bus.dmem_valid = 1'b0; bus.dmem_ready = 1'b0;
  endtask

  task automatic id(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                    input logic wr, input logic ll);
    bus.id_valid = 1'b1; bus.rs1_id = rs1; bus.rs2_id = rs2; bus.rd_id = rd;
    bus.id_regwrite = wr; bus.id_longlat = ll;
  endtask

  task automatic wb(input logic [4:0] rd);
    bus.wb_valid = 1'b1; bus.wb_rd = rd;
  endtask

  // Called at posedge+1 with inputs already driven; samples at posedge+3, ends at next posedge+1.
  task automatic cyc(input string tag, input logic [6:0] e);
    logic [6:0] obs;
    logic [6:0] x;
    string      t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #2;
    obs = {bus.stall, bus.flush_if_id, bus.flush_id_ex, bus.mem_timeout, bus.pending_cnt};
    x = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === x) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (stall,fif,fie,to,pc)", t, obs, x);
    end
    if (!rst && x[6]) exp_sc++;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sc(input string tag);
    checks++;
    assert (bus.stall_cycles === exp_sc) else begin
      errors++;
      $error("FAIL %s stall_cycles observed=%0d expected=%0d", tag, bus.stall_cycles, exp_sc);
    end
  endtask

  initial begin
    #60000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    idle();
    #1;
    // Reset: outputs gated low even with a memory wait and a branch present.
    bus.imem_ready = 1'b0; bus.branch_taken = 1'b1;
    cyc("rst_outputs", pk(0,0,0,0,0));
    chk_sc("rst_sc");
    idle();
    rst = 1'b0;
    cyc("rst_release", pk(0,0,0,0,0));

    // Test 1: load x5 then RAW on x5, released by bypassed writeback.
    idle(); id(5'd1, 5'd2, 5'd5, 1, 1);  cyc("t1_load_x5", pk(0,0,0,0,0));
    idle(); id(5'd5, 5'd0, 5'd8, 1, 0);  cyc("t1_raw_a",   pk(1,0,1,0,1));
    idle(); id(5'd5, 5'd0, 5'd8, 1, 0);  cyc("t1_raw_b",   pk(1,0,1,0,1));
    idle(); id(5'd5, 5'd0, 5'd8, 1, 0); wb(5'd5); cyc("t1_wb_bypass", pk(0,0,0,0,1));
    idle();                              cyc("t1_cleared", pk(0,0,0,0,0));
    chk_sc("t1_sc");

    // Test 2: fill the scoreboard, 5th long-latency op stalls on full.
    for (int k = 1; k <= 4; k++) begin
      idle(); id(5'd0, 5'd0, 5'(k), 1, 1);
      cyc($sformatf("t2_issue%0d", k), pk(0,0,0,0,k-1));
    end
    idle(); id(5'd0, 5'd0, 5'd6, 1, 1);  cyc("t2_full_a", pk(1,0,1,0,4));
    idle(); id(5'd0, 5'd0, 5'd6, 1, 1);  cyc("t2_full_b", pk(1,0,1,0,4));
    idle(); id(5'd0, 5'd0, 5'd6, 1, 1); wb(5'd1); cyc("t2_full_wb_same", pk(1,0,1,0,4));
    idle(); id(5'd0, 5'd0, 5'd6, 1, 1);  cyc("t2_fifth_issue", pk(0,0,0,0,3));
    idle();                              cyc("t2_after", pk(0,0,0,0,4));
    begin
      logic [4:0] regs [4];
      regs[0] = 5'd2; regs[1] = 5'd3; regs[2] = 5'd4; regs[3] = 5'd6;
      for (int k = 0; k < 4; k++) begin
        idle(); wb(regs[k]);
        cyc($sformatf("t2_drain%0d", k), pk(0,0,0,0,4-k));
      end
    end
    idle();                              cyc("t2_empty", pk(0,0,0,0,0));
    chk_sc("t2_sc");

    // Test 3: same-cycle clear and set of x7; set wins.
    idle(); id(5'd0, 5'd0, 5'd7, 1, 1);  cyc("t3_load_x7", pk(0,0,0,0,0));
    idle(); id(5'd0, 5'd0, 5'd7, 1, 1); wb(5'd7); cyc("t3_wb_and_set", pk(0,0,0,0,1));
    idle();                              cyc("t3_cnt_same", pk(0,0,0,0,1));
    idle(); id(5'd7, 5'd0, 5'd9, 1, 0);  cyc("t3_x7_pending", pk(1,0,1,0,1));
    idle(); id(5'd7, 5'd0, 5'd9, 1, 0); wb(5'd7); cyc("t3_x7_release", pk(0,0,0,0,1));
    idle(); wb(5'd9);                    cyc("t3_wb_not_pending", pk(0,0,0,0,0));
    idle();                              cyc("t3_no_underflow", pk(0,0,0,0,0));

    // Test 4: branch flush with hazard, then memory freeze suppresses flushes.
    idle(); id(5'd0, 5'd0, 5'd5, 1, 1);  cyc("t4_load_x5", pk(0,0,0,0,0));
    idle(); id(5'd5, 5'd0, 5'd10, 1, 1); bus.branch_taken = 1'b1;
    cyc("t4_branch_raw", pk(1,1,1,0,1));
    idle(); id(5'd5, 5'd0, 5'd10, 1, 1); bus.branch_taken = 1'b1;
    bus.dmem_valid = 1'b1; bus.dmem_ready = 1'b0;
    cyc("t4_branch_dmem", pk(1,0,0,0,1));
    idle();                              cyc("t4_no_set", pk(0,0,0,0,1));
    idle(); id(5'd0, 5'd0, 5'd11, 1, 1); bus.branch_taken = 1'b1;
    cyc("t4_branch_only", pk(0,1,1,0,1));
    idle(); wb(5'd5);                    cyc("t4_no_set2", pk(0,0,0,0,1));
    idle();                              cyc("t4_empty", pk(0,0,0,0,0));
    chk_sc("t4_sc");

    // Test 6: async reset in the middle of a memory wait with 3 pending.
    for (int k = 1; k <= 3; k++) begin
      idle(); id(5'd0, 5'd0, 5'(k), 1, 1);
      cyc($sformatf("t6_issue%0d", k), pk(0,0,0,0,k-1));
    end
    for (int k = 0; k < 3; k++) begin
      idle(); bus.imem_ready = 1'b0;
      cyc($sformatf("t6_memwait%0d", k), pk(1,0,0,0,3));
    end
    chk_sc("t6_sc_before");
    rst = 1'b1;
    exp_sc = '0;
    #1;
    chk_sc("t6_sc_async");
    cyc("t6_async_rst", pk(0,0,0,0,0));
    idle(); rst = 1'b0;
    cyc("t6_after_rst", pk(0,0,0,0,0));

    // Test 5: watchdog fault after 8 consecutive stall cycles; sticky until reset.
    for (int k = 1; k <= 8; k++) begin
      idle(); bus.imem_ready = 1'b0;
      cyc($sformatf("t5_wait%0d", k), pk(1,0,0,0,0));
    end
    idle(); bus.imem_ready = 1'b0;       cyc("t5_fault", pk(1,0,0,1,0));
    idle();                              cyc("t5_sticky_a", pk(1,0,0,1,0));
    idle(); id(5'd1, 5'd0, 5'd3, 1, 1);  cyc("t5_sticky_b", pk(1,0,0,1,0));
    idle(); bus.branch_taken = 1'b1;     cyc("t5_fault_branch", pk(1,1,1,1,0));
    chk_sc("t5_sc");
    idle(); rst = 1'b1;
    exp_sc = '0;
    cyc("t5_rst", pk(0,0,0,0,0));
    rst = 1'b0;
    cyc("t5_cleared", pk(0,0,0,0,0));
    chk_sc("t5_sc_cleared");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
